// File: rtl/modexp_ctrl_if.sv
// modexp_ctrl_if: bundles the request/response signals of modexp_ctrl and
// the operand/product lines to the Montgomery multiplier it drives.
//   slave  : modexp_ctrl side (receives request and mp_prod, drives the rest)
//   master : RSA top level plus monpro side
// Signals:
//   start, msg, exp, n, n_inv, r2 : request and operands
//   busy, done, err, result       : status and result
//   mp_calc, mp_a, mp_b, mp_n, mp_n_inv, mp_prod : monpro connection
interface modexp_ctrl_if #(
  parameter int K = 8
);
  logic         start;
  logic [K-1:0] msg;
  logic [K-1:0] exp;
  logic [K-1:0] n;
  logic [K-1:0] n_inv;
  logic [K-1:0] r2;
  logic         mp_calc;
  logic [K-1:0] mp_a;
  logic [K-1:0] mp_b;
  logic [K-1:0] mp_n;
  logic [K-1:0] mp_n_inv;
  logic [K:0]   mp_prod;
  logic         busy;
  logic         done;
  logic         err;
  logic [K-1:0] result;

  modport slave (
    input  start, msg, exp, n, n_inv, r2, mp_prod,
    output mp_calc, mp_a, mp_b, mp_n, mp_n_inv, busy, done, err, result
  );

  modport master (
    output start, msg, exp, n, n_inv, r2, mp_prod,
    input  mp_calc, mp_a, mp_b, mp_n, mp_n_inv, busy, done, err, result
  );
endinterface

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer computing
// m^e mod n through one external combinational Montgomery multiplier.
// One monpro operation per clock; each product is registered on the edge
// that ends its state.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : modexp_ctrl_if.slave (request, status, result, monpro lines)
//
// state       | meaning
// S_IDLE      | wait for start; latch operands, reject even modulus
// S_TO_MONT_M | mm <= monpro(m, R^2)   (m into Montgomery form)
// S_TO_MONT_1 | x  <= monpro(1, R^2)   (R mod n, Montgomery one)
// S_SQUARE    | x  <= monpro(x, x)
// S_MULT      | x  <= monpro(x, mm)    (exponent bit idx is set)
// S_FROM_MONT | result <= monpro(x, 1)
// S_DONE      | done pulse
module modexp_ctrl #(
  parameter int K = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  modexp_ctrl_if.slave  bus
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TO_MONT_M,
    S_TO_MONT_1,
    S_SQUARE,
    S_MULT,
    S_FROM_MONT,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [K-1:0]    m_reg, e_reg, n_reg, ninv_reg, r2_reg;
  logic [K-1:0]    mm, x, result_q;
  logic [IW-1:0]   idx;
  logic            err_q;

  logic            latch, err_nxt, idx_load, idx_dec;
  logic            mm_we, x_we, res_we;
  logic            calc;
  logic [K-1:0]    op_a, op_b;
  logic [K-1:0]    prod;
  logic            prod_msb_unused;

  // The product is always reduced below n, so the carry bit is never needed.
  assign prod            = bus.mp_prod[K-1:0];
  assign prod_msb_unused = bus.mp_prod[K];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      m_reg    <= '0;
      e_reg    <= '0;
      n_reg    <= '0;
      ninv_reg <= '0;
      r2_reg   <= '0;
      mm       <= '0;
      x        <= '0;
      idx      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (latch) begin
        m_reg    <= bus.msg;
        e_reg    <= bus.exp;
        n_reg    <= bus.n;
        ninv_reg <= bus.n_inv;
        r2_reg   <= bus.r2;
      end
      if (mm_we)    mm       <= prod;
      if (x_we)     x        <= prod;
      if (res_we)   result_q <= prod;
      if (idx_load) idx      <= IW'(K - 1);
      else if (idx_dec) idx  <= idx - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    err_nxt   = 1'b0;
    idx_load  = 1'b0;
    idx_dec   = 1'b0;
    mm_we     = 1'b0;
    x_we      = 1'b0;
    res_we    = 1'b0;
    calc      = 1'b0;
    op_a      = '0;
    op_b      = '0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          latch = 1'b1;
          // Montgomery reduction needs an odd modulus.
          if (!bus.n[0]) begin
            err_nxt = 1'b1;
          end else begin
            idx_load  = 1'b1;
            state_nxt = S_TO_MONT_M;
          end
        end
      end
      S_TO_MONT_M: begin
        calc      = 1'b1;
        op_a      = m_reg;
        op_b      = r2_reg;
        mm_we     = 1'b1;
        state_nxt = S_TO_MONT_1;
      end
      S_TO_MONT_1: begin
        calc      = 1'b1;
        op_a      = K'(1);
        op_b      = r2_reg;
        x_we      = 1'b1;
        state_nxt = S_SQUARE;
      end
      S_SQUARE: begin
        calc = 1'b1;
        op_a = x;
        op_b = x;
        x_we = 1'b1;
        // idx is consumed by MULT when the bit is set, so it only moves here
        // when no multiply follows.
        if (e_reg[idx]) begin
          state_nxt = S_MULT;
        end else if (idx == '0) begin
          state_nxt = S_FROM_MONT;
        end else begin
          idx_dec   = 1'b1;
          state_nxt = S_SQUARE;
        end
      end
      S_MULT: begin
        calc = 1'b1;
        op_a = x;
        op_b = mm;
        x_we = 1'b1;
        if (idx == '0) begin
          state_nxt = S_FROM_MONT;
        end else begin
          idx_dec   = 1'b1;
          state_nxt = S_SQUARE;
        end
      end
      S_FROM_MONT: begin
        calc      = 1'b1;
        op_a      = x;
        op_b      = K'(1);
        res_we    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.mp_calc  = calc;
  assign bus.mp_a     = op_a;
  assign bus.mp_b     = op_b;
  assign bus.mp_n     = n_reg;
  assign bus.mp_n_inv = ninv_reg;
  assign bus.busy     = calc;
  assign bus.done     = (state == S_DONE);
  assign bus.err      = err_q;
  assign bus.result   = result_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: directed plus randomized checks of modexp_ctrl against a
// plain-arithmetic model of modular exponentiation. The bench also plays the
// role of the combinational monpro (a*b*R^-1 mod n).
module tb_modexp_ctrl;
  localparam int K = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  modexp_ctrl_if #(.K(K)) bus ();
  modexp_ctrl #(.K(K)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int passes = 0;

  // Montgomery product via REDC with plain integers.
  function automatic logic [K:0] monpro(input logic [K-1:0] a, b, nn, ni);
    int unsigned t, q, u;
    t = int'(a) * int'(b);
    q = ((t & 32'hFF) * int'(ni)) & 32'hFF;
    u = (t + q * int'(nn)) >> 8;
    if (u >= int'(nn)) u = u - int'(nn);
    return u[K:0];
  endfunction

  always_comb bus.mp_prod = monpro(bus.mp_a, bus.mp_b, bus.mp_n, bus.mp_n_inv);

  function automatic int unsigned modpow(input int unsigned m, e, nn);
    int unsigned r;
    r = 1 % nn;
    for (int i = 0; i < int'(e); i++) r = (r * m) % nn;
    return r;
  endfunction

  function automatic int unsigned calc_ninv(input int unsigned nn);
    for (int v = 0; v < 256; v++)
      if (((nn * v) & 32'hFF) == 32'hFF) return v;
    return 0;
  endfunction

  task automatic check(input string tag, input int unsigned obs, input int unsigned expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Caller is positioned at a negedge; the request is sampled on the next posedge.
  task automatic run(input int unsigned m, e, nn, input bit disturb, input string tag);
    int unsigned exp_res, exp_lat, cyc, busy_cnt, prev;
    bit stable, calc_ok, seen;
    exp_res = modpow(m, e, nn);
    exp_lat = 3 + K + $countones(e[K-1:0]);
    prev    = bus.result;
    bus.start = 1'b1;
    bus.msg   = m[K-1:0];
    bus.exp   = e[K-1:0];
    bus.n     = nn[K-1:0];
    bus.n_inv = calc_ninv(nn);
    bus.r2    = (65536 % nn);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0; busy_cnt = 0; stable = 1; calc_ok = 1; seen = 0;
    while (cyc < 200) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (bus.mp_calc !== bus.busy) calc_ok = 0;
      if (bus.result !== prev[K-1:0]) stable = 0;
      if (disturb) begin
        bus.start = 1'($urandom);
        bus.msg   = K'($urandom);
        bus.exp   = K'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    // A start during the done cycle must be ignored.
    bus.start = disturb;
    check({tag, " done_seen"}, seen, 1);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, exp_lat);
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " result_stable"}, stable, 1);
    check({tag, " calc_eq_busy"}, calc_ok, 1);
    check({tag, " done_ops_zero"}, {bus.mp_calc, bus.mp_a, bus.mp_b}, 0);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " done_pulse"}, bus.done, 0);
    check({tag, " busy_after"}, bus.busy, 0);
    check({tag, " result_hold"}, bus.result, exp_res);
  endtask

  task automatic run_err(input int unsigned nn);
    int unsigned prev;
    prev = bus.result;
    bus.start = 1'b1;
    bus.n     = nn[K-1:0];
    bus.msg   = K'($urandom);
    bus.exp   = K'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    check("err pulse", bus.err, 1);
    check("err busy", bus.busy, 0);
    @(negedge clk);
    check("err single", bus.err, 0);
    check("err busy2", bus.busy, 0);
    check("err result_hold", bus.result, prev);
  endtask

  initial begin
    int unsigned nn, m, e, quiet;
    bus.start = 1'b0;
    bus.msg = '0; bus.exp = '0; bus.n = '0; bus.n_inv = '0; bus.r2 = '0;
    #1;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset err", bus.err, 0);
    check("reset outs", {bus.mp_calc, bus.mp_a, bus.mp_b, bus.mp_n, bus.mp_n_inv}, 0);
    check("reset result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(88, 7, 187, 0, "enc");
    run(11, 23, 187, 0, "dec");
    run(88, 0, 187, 0, "e0");
    run(0, 5, 187, 0, "m0");
    run_err(186);
    run(88, 7, 187, 1, "disturb");
    @(negedge clk);
    run(0, 0, 1, 0, "n1");

    // Abort during the squaring phase.
    bus.start = 1'b1; bus.msg = 8'd88; bus.exp = 8'd7; bus.n = 8'd187;
    bus.n_inv = 8'd141; bus.r2 = 8'd86;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort err", bus.err, 0);
    check("abort outs", {bus.mp_calc, bus.mp_a, bus.mp_b, bus.mp_n, bus.mp_n_inv}, 0);
    check("abort result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.busy) quiet = 0;
    end
    check("abort no_done", quiet, 1);
    run(88, 7, 187, 0, "post_abort");

    for (int i = 0; i < 10; i++) begin
      nn = $urandom_range(1, 127) * 2 + 1;
      m  = $urandom_range(0, nn - 1);
      e  = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run(m, e, nn, 0, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
